mips_alu_mdu: RTL
=================

Name: mips_alu_mdu

Overview:
- Parametrised next-generation execute unit for the MIPS datapath. Replaces the fixed 32-bit ALU.
- Adds XOR, NOR, arithmetic right shift, variable shift amount, signed and unsigned set-less-than, and a signed-overflow flag.
- Adds a multi-cycle multiply/divide unit (MULT/MULTU/DIV/DIVU) with architectural HI/LO registers and a start/busy/done handshake that the control unit uses to stall.

Parameters:
- WIDTH, 32, datapath width; must be even and at least 8.
- SH_W, $clog2(WIDTH), shift-amount width.
- OP_W, 4, alu_ctrl width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in0  input  WIDTH  operand A (rs).
- in1  input  WIDTH  operand B (rt or immediate).
- alu_ctrl  input  OP_W  operation select.
- shamt  input  SH_W  shift amount, used when var_shift=0.
- var_shift  input  1  1: shift amount is in0[SH_W-1:0] (SLLV/SRLV/SRAV).
- start  input  1  launch the MDU operation selected by alu_ctrl.
- alu_result  output  WIDTH  combinational result.
- zero  output  1  alu_result == 0.
- overflow  output  1  signed overflow, valid for ADD and SUB only; 0 otherwise.
- busy  output  1  MDU is computing.
- done  output  1  one-cycle pulse; HI/LO have been updated.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 SLT (signed), 4 SLL, 5 SRL, 6 SUB, 7 SLTU
  - 8 XOR, 9 NOR, 10 SRA
  - 11 MULT, 12 MULTU, 13 DIV, 14 DIVU, 15 reserved
- Combinational path (opcodes 0-10):
  - Result is ready in the same cycle and is independent of busy.
  - SLT and SLTU produce {0...,bit}.
  - ADD/SUB wrap modulo 2^WIDTH. overflow=1 when both operands of the effective addition have the same sign and the sum has the opposite sign.
- Opcodes 11-15: alu_result=0 and zero=1.
- Reset (asynchronous): state IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset asserted mid-operation aborts it and leaves HI/LO at 0.
- FSM states IDLE, CALC, FIX:
  - IDLE: start=1 with alu_ctrl in 11..14 at edge N latches |operands| (signed ops take magnitudes; unsigned ops use raw values), records the result signs, clears the accumulator, goes to CALC, busy=1.
  - IDLE: start with any other opcode is ignored.
  - CALC: one bit per cycle. Shift-add for multiply; restoring shift-subtract for divide. Runs exactly WIDTH cycles (edges N+1..N+WIDTH), then goes to FIX.
  - FIX, edge N+WIDTH+1: apply signs and write HI/LO. done=1 and busy=0 for the following cycle; return to IDLE.
- Latency: done is visible WIDTH+1 cycles after the start edge.
- start while busy=1 is ignored and does not modify operands.
- start in the done cycle is accepted (back-to-back).
- Multiply result: {hi,lo} = 2*WIDTH-bit product. Signed product is negated when the operand signs differ.
- Divide result: lo = quotient, hi = remainder. Signed: quotient negative when the operand signs differ; remainder takes the sign of in0 (truncating division).
- Divide by zero: no exception, and the full latency still applies.
  - DIVU: lo = all ones, hi = in0.
  - DIV: the sign fixups are applied to those magnitudes.
- Signed most-negative / -1: lo = most-negative value, hi = 0 (wraps, no flag).
- hi/lo hold their values except at the FIX edge.

Decomposition:
- Shared package mips_alu_pkg holds:
  - opcode localparams (OP_AND..OP_DIVU)
  - FSM state encoding
  - helper function for signed overflow
- One natural sub-module: mips_mdu_iter. It contains the FSM, counter, and iterative multiply/divide datapath. The top level holds the combinational ALU and instantiates it.

Test Plan:
- WIDTH=32. ADD 0x7FFFFFFF+1 -> alu_result 0x80000000, overflow=1, zero=0. SUB 5-5 -> 0, zero=1, overflow=0.
- SRA in1=0xF0000000, shamt=4 -> 0xFF000000. SLLV var_shift=1, in0=35, in1=1 -> shift by 3 = 0x8. SLT -1 vs 1 -> 1; SLTU same operands -> 0.
- MULT in0=-3, in1=7 with start at edge N:
  - busy over edges N+1..N+33
  - done visible only after edge N+33
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB
  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/0 -> lo=0xFFFFFFFF, hi=100.
- Second start pulsed mid-operation is ignored and HI/LO match the first operation. Start in the done cycle launches the next operation, with done again WIDTH+1 cycles later.
- rst_n dropped at CALC cycle 10 -> busy=0, hi=lo=0 immediately with no done pulse. A new start after release completes normally.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS execute unit: opcodes, MDU FSM states and
// the signed-overflow helper used by the combinational ALU.
package mips_alu_pkg;

    localparam int unsigned OP_AND  = 0;
    localparam int unsigned OP_OR   = 1;
    localparam int unsigned OP_ADD  = 2;
    localparam int unsigned OP_SLT  = 3;
    localparam int unsigned OP_SLL  = 4;
    localparam int unsigned OP_SRL  = 5;
    localparam int unsigned OP_SUB  = 6;
    localparam int unsigned OP_SLTU = 7;
    localparam int unsigned OP_XOR  = 8;
    localparam int unsigned OP_NOR  = 9;
    localparam int unsigned OP_SRA  = 10;
    localparam int unsigned OP_MULT = 11;
    localparam int unsigned OP_MULTU = 12;
    localparam int unsigned OP_DIV  = 13;
    localparam int unsigned OP_DIVU = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    // Overflow of an addition: operands agree in sign, sum disagrees.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/mips_alu_mdu_if.sv
// Execute-unit bus: operands/opcode/start from control, results and the
// MDU handshake back. master = control side, slave = execute unit.
interface mips_alu_mdu_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SH_W  = $clog2(WIDTH),
    parameter int unsigned OP_W  = 4
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [OP_W-1:0]  alu_ctrl;
    logic [SH_W-1:0]  shamt;
    logic             var_shift;
    logic             start;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in0, in1, alu_ctrl, shamt, var_shift, start,
        input  alu_result, zero, overflow, busy, done, hi, lo
    );

    modport slave (
        input  in0, in1, alu_ctrl, shamt, var_shift, start,
        output alu_result, zero, overflow, busy, done, hi, lo
    );
endinterface

// File: rtl/mips_mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers.
// Ports: clk, rst_n; start/op launch MULT/MULTU/DIV/DIVU on operands a/b;
// busy while computing, done one-cycle pulse when hi/lo have been written.
module mips_mdu_iter
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SH_W  = $clog2(WIDTH),
    parameter int unsigned OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned PW = 2 * WIDTH;

    mdu_state_e       state;
    logic [SH_W-1:0]  cnt;
    logic             div_r;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] opnd;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0] p_hi;   // partial product high / partial remainder
    logic [WIDTH-1:0] p_lo;   // multiplier bits / dividend-then-quotient bits

    logic             is_mdu, is_sgn, is_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] p_hi_n, p_lo_n, q_fix, r_fix;
    logic [PW-1:0]    prod, prod_fix;

    // Opcode decode and operand magnitudes for launch
    always_comb begin
        is_mdu = (op == OP_W'(OP_MULT)) || (op == OP_W'(OP_MULTU)) ||
                 (op == OP_W'(OP_DIV))  || (op == OP_W'(OP_DIVU));
        is_sgn = (op == OP_W'(OP_MULT)) || (op == OP_W'(OP_DIV));
        is_div = (op == OP_W'(OP_DIV))  || (op == OP_W'(OP_DIVU));
        a_neg  = is_sgn & a[WIDTH-1];
        b_neg  = is_sgn & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
    end

    // One iteration: shift-add multiply or restoring shift-subtract divide
    always_comb begin
        mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {p_hi, p_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (div_r) begin
            // Borrow out of the extra top bit means the divisor did not fit
            p_hi_n = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            p_lo_n = {p_lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            p_hi_n = mul_sum[WIDTH:1];
            p_lo_n = {mul_sum[0], p_lo[WIDTH-1:1]};
        end
    end

    // Sign fixups applied in FIX
    always_comb begin
        prod     = {p_hi, p_lo};
        prod_fix = neg_q ? -prod : prod;
        q_fix    = neg_q ? -p_lo : p_lo;
        r_fix    = neg_r ? -p_hi : p_hi;
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            div_r <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            opnd  <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && is_mdu) begin
                        div_r <= is_div;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        opnd  <= is_div ? b_mag : a_mag;
                        p_lo  <= is_div ? a_mag : b_mag;
                        p_hi  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    p_hi <= p_hi_n;
                    p_lo <= p_lo_n;
                    cnt  <= cnt + SH_W'(1);
                    if (cnt == SH_W'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (div_r) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        hi <= prod_fix[PW-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mips_alu_mdu.sv
// MIPS execute unit: single-cycle ALU plus iterative multiply/divide.
// Ports: clk, rst_n; bus (slave) carries in0/in1/alu_ctrl/shamt/var_shift/
// start in, and alu_result/zero/overflow (combinational) plus
// busy/done/hi/lo (registered) out.
module mips_alu_mdu
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SH_W  = $clog2(WIDTH),
    parameter int unsigned OP_W  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mips_alu_mdu_if.slave  bus
);
    logic [SH_W-1:0]  sh_amt;
    logic [WIDTH-1:0] sum, diff, res;
    logic             ovf;

    // Combinational ALU; independent of the MDU state
    always_comb begin
        sh_amt = bus.var_shift ? bus.in0[SH_W-1:0] : bus.shamt;
        sum    = bus.in0 + bus.in1;
        diff   = bus.in0 - bus.in1;
        res    = '0;
        ovf    = 1'b0;
        case (bus.alu_ctrl)
            OP_W'(OP_AND):  res = bus.in0 & bus.in1;
            OP_W'(OP_OR):   res = bus.in0 | bus.in1;
            OP_W'(OP_ADD): begin
                res = sum;
                ovf = add_ovf(bus.in0[WIDTH-1], bus.in1[WIDTH-1], sum[WIDTH-1]);
            end
            OP_W'(OP_SLT):  res = {{(WIDTH-1){1'b0}}, $signed(bus.in0) < $signed(bus.in1)};
            OP_W'(OP_SLL):  res = bus.in1 << sh_amt;
            OP_W'(OP_SRL):  res = bus.in1 >> sh_amt;
            OP_W'(OP_SUB): begin
                res = diff;
                // Subtraction is in0 + ~in1 + 1, so the effective addend sign is inverted
                ovf = add_ovf(bus.in0[WIDTH-1], ~bus.in1[WIDTH-1], diff[WIDTH-1]);
            end
            OP_W'(OP_SLTU): res = {{(WIDTH-1){1'b0}}, bus.in0 < bus.in1};
            OP_W'(OP_XOR):  res = bus.in0 ^ bus.in1;
            OP_W'(OP_NOR):  res = ~(bus.in0 | bus.in1);
            OP_W'(OP_SRA):  res = WIDTH'($signed(bus.in1) >>> sh_amt);
            default:        res = '0;
        endcase
    end

    assign bus.alu_result = res;
    assign bus.zero       = (res == '0);
    assign bus.overflow   = ovf;

    mips_mdu_iter #(
        .WIDTH (WIDTH),
        .SH_W  (SH_W),
        .OP_W  (OP_W)
    ) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bus.start),
        .op    (bus.alu_ctrl),
        .a     (bus.in0),
        .b     (bus.in1),
        .busy  (bus.busy),
        .done  (bus.done),
        .hi    (bus.hi),
        .lo    (bus.lo)
    );

endmodule
